// File: rtl/disasm_inst.sv
// rtl/disasm_inst.sv - registered RV32I disassembler to a 32-char ASCII string; DISASM_PSEUDO_EN enables nop/j/ret aliases
module disasm_inst (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inst_val,
    input  logic [31:0]  inst,
    output logic         dasm_val,
    output logic [255:0] dasm
);

    localparam logic [7:0] SP = 8'h20;
    localparam logic [7:0] CM = 8'h2c;

    typedef enum logic [3:0] {
        F_R, F_I, F_S, F_B, F_U, F_J, F_IMM, F_NONE, F_ILL
    } fmt_t;

    function automatic logic [7:0] hex_ch(input logic [3:0] d);
        hex_ch = (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h57 + {4'h0, d});
    endfunction

    function automatic logic [79:0] hex_str(input logic [31:0] v);
        hex_str[79:64] = 16'h3078;
        for (int i = 0; i < 8; i++)
            hex_str[63-8*i -: 8] = hex_ch(v[31-4*i -: 4]);
    endfunction

    function automatic logic [23:0] reg_str(input logic [4:0] r);
        logic [4:0] t;
        t = r / 5'd10;
        reg_str = {8'h72, 8'h30 + {3'b000, t}, 8'h30 + {3'b000, r - t * 5'd10}};
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'h000};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign shamt  = {27'd0, inst[24:20]};

    fmt_t         fmt;
    logic [63:0]  mnem;
    logic [31:0]  imm;
    logic [191:0] ops;

    always_comb begin
        fmt  = F_ILL;
        mnem = "???     ";
        imm  = 32'd0;
        case (opcode)
            7'b0110011: begin
                fmt = F_R;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  mnem = "add     ";
                        3'b001:  mnem = "sll     ";
                        3'b010:  mnem = "slt     ";
                        3'b011:  mnem = "sltu    ";
                        3'b100:  mnem = "xor     ";
                        3'b101:  mnem = "srl     ";
                        3'b110:  mnem = "or      ";
                        default: mnem = "and     ";
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    mnem = "sub     ";
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    mnem = "sra     ";
                end else begin
                    fmt = F_ILL;
                end
            end
            7'b0010011: begin
                fmt = F_I;
                imm = imm_i;
                case (f3)
                    3'b000: mnem = "addi    ";
                    3'b010: mnem = "slti    ";
                    3'b011: mnem = "sltiu   ";
                    3'b100: mnem = "xori    ";
                    3'b110: mnem = "ori     ";
                    3'b111: mnem = "andi    ";
                    3'b001: begin
                        imm = shamt;
                        if (f7 == 7'b0000000) mnem = "slli    ";
                        else fmt = F_ILL;
                    end
                    default: begin
                        imm = shamt;
                        if (f7 == 7'b0000000) mnem = "srli    ";
                        else if (f7 == 7'b0100000) mnem = "srai    ";
                        else fmt = F_ILL;
                    end
                endcase
            end
            7'b0000011: begin
                fmt = F_I;
                imm = imm_i;
                case (f3)
                    3'b000:  mnem = "lb      ";
                    3'b001:  mnem = "lh      ";
                    3'b010:  mnem = "lw      ";
                    3'b100:  mnem = "lbu     ";
                    3'b101:  mnem = "lhu     ";
                    default: fmt  = F_ILL;
                endcase
            end
            7'b1100111: begin
                imm = imm_i;
                if (f3 == 3'b000) begin
                    fmt  = F_I;
                    mnem = "jalr    ";
                end
            end
            7'b0100011: begin
                fmt = F_S;
                imm = imm_s;
                case (f3)
                    3'b000:  mnem = "sb      ";
                    3'b001:  mnem = "sh      ";
                    3'b010:  mnem = "sw      ";
                    default: fmt  = F_ILL;
                endcase
            end
            7'b1100011: begin
                fmt = F_B;
                imm = imm_b;
                case (f3)
                    3'b000:  mnem = "beq     ";
                    3'b001:  mnem = "bne     ";
                    3'b100:  mnem = "blt     ";
                    3'b101:  mnem = "bge     ";
                    3'b110:  mnem = "bltu    ";
                    3'b111:  mnem = "bgeu    ";
                    default: fmt  = F_ILL;
                endcase
            end
            7'b0110111: begin fmt = F_U; imm = imm_u; mnem = "lui     "; end
            7'b0010111: begin fmt = F_U; imm = imm_u; mnem = "auipc   "; end
            7'b1101111: begin fmt = F_J; imm = imm_j; mnem = "jal     "; end
            7'b0001111: begin
                if (f3 == 3'b000) begin
                    fmt  = F_NONE;
                    mnem = "fence   ";
                end
            end
            7'b1110011: begin
                if (inst == 32'h00000073) begin
                    fmt  = F_NONE;
                    mnem = "ecall   ";
                end else if (inst == 32'h00100073) begin
                    fmt  = F_NONE;
                    mnem = "ebreak  ";
                end
            end
            default: fmt = F_ILL;
        endcase

`ifdef DISASM_PSEUDO_EN
        if (inst == 32'h00000013) begin
            fmt  = F_NONE;
            mnem = "nop     ";
        end else if (inst == 32'h00008067) begin
            fmt  = F_NONE;
            mnem = "ret     ";
        end else if (fmt == F_J && rd == 5'd0) begin
            fmt  = F_IMM;
            mnem = "j       ";
        end
`endif

        // An illegal word always shows the generic mnemonic, even if an arm set one first
        if (fmt == F_ILL)
            mnem = "???     ";

        case (fmt)
            F_R:     ops = {reg_str(rd), CM, reg_str(rs1), CM, reg_str(rs2), {13{SP}}};
            F_I:     ops = {reg_str(rd), CM, reg_str(rs1), CM, hex_str(imm), {6{SP}}};
            F_S:     ops = {reg_str(rs2), CM, reg_str(rs1), CM, hex_str(imm), {6{SP}}};
            F_B:     ops = {reg_str(rs1), CM, reg_str(rs2), CM, hex_str(imm), {6{SP}}};
            F_U,
            F_J:     ops = {reg_str(rd), CM, hex_str(imm), {10{SP}}};
            F_IMM:   ops = {hex_str(imm), {14{SP}}};
            F_ILL:   ops = {hex_str(inst), {14{SP}}};
            default: ops = {24{SP}};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dasm     <= {32{SP}};
            dasm_val <= 1'b0;
        end else begin
            dasm_val <= inst_val;
            if (inst_val)
                dasm <= {mnem, ops};
        end
    end

endmodule

// File: tb/tb_disasm_inst.sv
// tb/tb_disasm_inst.sv - directed self-checking bench for disasm_inst
module tb_disasm_inst;

    logic         clk;
    logic         reset_n;
    logic         inst_val;
    logic [31:0]  inst;
    logic         dasm_val;
    logic [255:0] dasm;

    int n_tests = 0;
    int n_fail  = 0;

    disasm_inst dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .inst_val (inst_val),
        .inst     (inst),
        .dasm_val (dasm_val),
        .dasm     (dasm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [255:0] str32(input string s);
        logic [255:0] r;
        r = {32{8'h20}};
        for (int i = 0; i < s.len() && i < 32; i++)
            r[255-8*i -: 8] = s[i];
        return r;
    endfunction

    // Called at a falling edge; applies inputs and returns at the next falling edge.
    task automatic step(input logic v, input logic [31:0] w);
        inst_val = v;
        inst     = w;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [255:0] exp;
        exp = str32("");
        reset_n  = 1'b1;
        inst_val = 1'b0;
        inst     = 32'd0;
        #1 reset_n = 1'b0;
        #1;
        n_tests++;
        if (dasm !== exp) begin
            n_fail++;
            $display("FAIL reset_dasm: got \"%s\" exp \"%s\"", dasm, exp);
        end
        n_tests++;
        if (dasm_val !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_val: got %b exp 0", dasm_val);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 32'h00500093);
        n_tests++;
        if (dasm !== exp || dasm_val !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got \"%s\" val %b exp spaces val 0", dasm, dasm_val);
        end
    endtask

    task automatic test_addi;
        logic [255:0] exp;
        exp = str32("addi    r01,r00,0x00000005");
        step(1'b1, 32'h00500093);
        n_tests++;
        if (dasm !== exp) begin
            n_fail++;
            $display("FAIL addi: got \"%s\" exp \"%s\"", dasm, exp);
        end
        n_tests++;
        if (dasm_val !== 1'b1) begin
            n_fail++;
            $display("FAIL addi_val: got %b exp 1", dasm_val);
        end
    endtask

    task automatic test_back_to_back;
        logic [255:0] exp0, exp1;
        exp0 = str32("add     r03,r01,r02");
        exp1 = str32("lui     r10,0x12345000");
        step(1'b1, 32'h002081b3);
        n_tests++;
        if (dasm !== exp0 || dasm_val !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_add: got \"%s\" val %b exp \"%s\" val 1", dasm, dasm_val, exp0);
        end
        step(1'b1, 32'h12345537);
        n_tests++;
        if (dasm !== exp1 || dasm_val !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_lui: got \"%s\" val %b exp \"%s\" val 1", dasm, dasm_val, exp1);
        end
    endtask

    task automatic test_formats;
        logic [31:0]  words [13];
        string        exps  [13];
        logic [255:0] exp;
        words[0]  = 32'hfe000ee3; exps[0]  = "beq     r00,r00,0xfffffffc";
        words[1]  = 32'h40000033; exps[1]  = "sub     r00,r00,r00";
        words[2]  = 32'h02000033; exps[2]  = "???     0x02000033";
        words[3]  = 32'h00512423; exps[3]  = "sw      r05,r02,0x00000008";
        words[4]  = 32'h40315093; exps[4]  = "srai    r01,r02,0x00000003";
        words[5]  = 32'h02009093; exps[5]  = "???     0x02009093";
        words[6]  = 32'hffc0a183; exps[6]  = "lw      r03,r01,0xfffffffc";
        words[7]  = 32'hffffff97; exps[7]  = "auipc   r31,0xfffff000";
        words[8]  = 32'h00000073; exps[8]  = "ecall";
        words[9]  = 32'h00100073; exps[9]  = "ebreak";
        words[10] = 32'h0ff0000f; exps[10] = "fence";
`ifdef DISASM_PSEUDO_EN
        words[11] = 32'hff9ff06f; exps[11] = "j       0xfffffff8";
        words[12] = 32'h00008067; exps[12] = "ret";
`else
        words[11] = 32'hff9ff06f; exps[11] = "jal     r00,0xfffffff8";
        words[12] = 32'h00008067; exps[12] = "jalr    r00,r01,0x00000000";
`endif
        for (int i = 0; i < 13; i++) begin
            exp = str32(exps[i]);
            step(1'b1, words[i]);
            n_tests++;
            if (dasm !== exp || dasm_val !== 1'b1) begin
                n_fail++;
                $display("FAIL fmt_%08h: got \"%s\" val %b exp \"%s\" val 1", words[i], dasm, dasm_val, exp);
            end
        end
    endtask

    task automatic test_hold;
        logic [255:0] exp;
        exp = str32("???     0xffffffff");
        step(1'b1, 32'hffffffff);
        n_tests++;
        if (dasm !== exp || dasm_val !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_load: got \"%s\" val %b exp \"%s\" val 1", dasm, dasm_val, exp);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h00000013);
            n_tests++;
            if (dasm !== exp || dasm_val !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d: got \"%s\" val %b exp \"%s\" val 0", i, dasm, dasm_val, exp);
            end
        end
    endtask

    task automatic test_nop;
        logic [255:0] exp;
`ifdef DISASM_PSEUDO_EN
        exp = str32("nop");
`else
        exp = str32("addi    r00,r00,0x00000000");
`endif
        step(1'b1, 32'h00000013);
        n_tests++;
        if (dasm !== exp || dasm_val !== 1'b1) begin
            n_fail++;
            $display("FAIL nop: got \"%s\" val %b exp \"%s\" val 1", dasm, dasm_val, exp);
        end
    endtask

    task automatic test_mid_reset;
        logic [255:0] sp;
        sp = str32("");
        step(1'b1, 32'h00500093);
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (dasm !== sp || dasm_val !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got \"%s\" val %b exp spaces val 0", dasm, dasm_val);
        end
        inst_val = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 32'h002081b3);
        n_tests++;
        if (dasm !== sp || dasm_val !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: got \"%s\" val %b exp spaces val 0", dasm, dasm_val);
        end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_back_to_back;
        test_formats;
        test_hold;
        test_nop;
        test_mid_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
